// File: rtl/fb_pkg.sv
// Shared framebuffer types: default geometry, 4:4:4 pixel word and arbiter grant encoding.
package fb_pkg;

    localparam int FB_AW = 19;
    localparam int FB_DW = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } fb_pix_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } fb_gnt_e;

endpackage

// File: rtl/fb_lat_pipe.sv
// Read-issue flag delay line: valid trails issue by LAT cycles, load is one cycle earlier.
// No backpressure; async clear drops every read still in flight.
module fb_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic load,
    output logic valid
);

    logic [LAT-1:0] sr;

    generate
        if (LAT == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= issue;
            end
            assign load = issue;
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[LAT-2:0], issue};
            end
            assign load = sr[LAT-2];
        end
    endgenerate

    assign valid = sr[LAT-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: read-first grant, writer forced after WR_MAX_WAIT stalls.
// Grants are combinational, RAM strobes registered, read data 1+MEM_LAT cycles after grant.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int AW          = FB_AW,
    parameter int DW          = FB_DW,
    parameter int MEM_LAT     = 1,
    parameter int WR_MAX_WAIT = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_gnt_o,
    output logic          rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_gnt_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          starve_o
);

    localparam logic [7:0] WAIT_MAX = 8'(WR_MAX_WAIT);

    logic       run_q;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       rd_load;
    fb_gnt_e    gnt;

    // run_q keeps grants off until the first edge after reset release
    always_comb begin
        gnt = GNT_NONE;
        if (run_q) begin
            if (starve_o) begin
                if (wr_req_i)      gnt = GNT_WR;
                else if (rd_req_i) gnt = GNT_RD;
            end else begin
                if (rd_req_i)      gnt = GNT_RD;
                else if (wr_req_i) gnt = GNT_WR;
            end
        end
    end

    assign rd_gnt_o = (gnt == GNT_RD);
    assign wr_gnt_o = (gnt == GNT_WR);

    always_comb begin
        wait_d = '0;
        if (run_q && wr_req_i && !wr_gnt_o) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run_q       <= 1'b0;
            wait_q      <= '0;
            starve_o    <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rd_data_o   <= '0;
        end else begin
            run_q    <= 1'b1;
            wait_q   <= wait_d;
            starve_o <= (wait_d == WAIT_MAX);
            mem_en_o <= (gnt != GNT_NONE);
            mem_we_o <= (gnt == GNT_WR);
            case (gnt)
                GNT_RD: mem_addr_o <= rd_addr_i;
                GNT_WR: begin
                    mem_addr_o  <= wr_addr_i;
                    mem_wdata_o <= wr_data_i;
                end
                default: ;
            endcase
            if (rd_load) rd_data_o <= mem_rdata_i;
        end
    end

    fb_lat_pipe #(
        .LAT (MEM_LAT)
    ) u_lat_pipe (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .issue (mem_en_o & ~mem_we_o),
        .load  (rd_load),
        .valid (rd_valid_o)
    );

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: MEM_LAT=2 instance checked every cycle against a queue-based model,
// MEM_LAT=4 instance shares the stimulus and is checked for pulse counts and reset flushing.
module tb_fb_port_arbiter;

    localparam int AW   = 19;
    localparam int DW   = 12;
    localparam int LAT  = 2;
    localparam int WMAX = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    logic          rd_gnt, rd_valid, wr_gnt, mem_en, mem_we, starve;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          rd_gnt4, rd_valid4, wr_gnt4, mem_en4, mem_we4, starve4;
    logic [DW-1:0] rd_data4, mem_wdata4, mem_rdata4;
    logic [AW-1:0] mem_addr4;

    always #5 clk = ~clk;

    fb_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .WR_MAX_WAIT(WMAX)) u_dut (
        .clk_i(clk), .rstn_i(rstn),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .starve_o(starve)
    );

    fb_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(4), .WR_MAX_WAIT(WMAX)) u_dut4 (
        .clk_i(clk), .rstn_i(rstn),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt4),
        .rd_valid_o(rd_valid4), .rd_data_o(rd_data4),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt4),
        .mem_en_o(mem_en4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4),
        .mem_wdata_o(mem_wdata4), .mem_rdata_i(mem_rdata4), .starve_o(starve4)
    );

    // RAM models returning addr[11:0]; data is sampled MEM_LAT edges after the enable edge
    logic [DW-1:0] ram2_q;
    logic [DW-1:0] ram4_q [3];
    always @(posedge clk) begin
        ram2_q    <= mem_addr[DW-1:0];
        ram4_q[0] <= mem_addr4[DW-1:0];
        ram4_q[1] <= ram4_q[0];
        ram4_q[2] <= ram4_q[1];
    end
    assign mem_rdata  = ram2_q;
    assign mem_rdata4 = ram4_q[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    rd_t           m_q[$];
    bit            m_run, m_starve, m_en, m_we;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    int            cyc;
    bit            e_rg, e_wg;
    bit            s_rn, s_rr, s_wr;
    logic [AW-1:0] s_ra, s_wa;
    logic [DW-1:0] s_wd;

    task automatic model_reset();
        m_run = 0; m_starve = 0; m_en = 0; m_we = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_q.delete();
    endtask

    // Called at a falling edge: drive inputs, then compare against the model's view of this cycle.
    task automatic apply(input bit rn, input bit rr, input logic [AW-1:0] ra,
                         input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit ev;
        rstn = rn; rd_req = rr; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
        s_rn = rn; s_rr = rr; s_ra = ra; s_wr = wr; s_wa = wa; s_wd = wd;
        #1;
        if (!rn) model_reset();
        e_rg = 0; e_wg = 0;
        if (rn && m_run) begin
            if (m_starve) begin e_wg = wr; e_rg = rr && !wr; end
            else          begin e_rg = rr; e_wg = wr && !rr; end
        end
        ev = (m_q.size() > 0) && (m_q[0].due == cyc);
        if (ev) begin
            m_rdata = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk("rd_gnt",   rd_gnt,   e_rg);
        chk("wr_gnt",   wr_gnt,   e_wg);
        chk("starve",   starve,   m_starve);
        chk("mem_en",   mem_en,   m_en);
        chk("mem_we",   mem_we,   m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("rd_valid", rd_valid, ev);
        chk("rd_data",  rd_data,  m_rdata);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    // Model the rising edge, then move to the next falling edge.
    task automatic advance();
        if (s_rn) begin
            if (e_rg) m_q.push_back('{cyc + 1 + LAT, s_ra[DW-1:0]});
            m_en = e_rg || e_wg;
            m_we = e_wg;
            if (e_rg) m_addr = s_ra;
            if (e_wg) begin m_addr = s_wa; m_wdata = s_wd; end
            if (!m_run || !s_wr || e_wg) m_wait = 0;
            else if (m_wait < WMAX)      m_wait++;
            m_starve = (m_wait == WMAX);
            m_run = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1, 0, '0, 0, '0, '0);
            advance();
        end
    endtask

    task automatic do_reset();
        apply(0, 0, '0, 0, '0, '0);
        advance();
        idle(1);
    endtask

    typedef struct packed { bit rr, wr, erg, ewg, een, ewe; } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  last, nwg, nst, nrg, nv, nv4, first_v, last_v;
        bit  pend;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;

        tbl[0] = '{1, 1, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 1};
        tbl[3] = '{1, 0, 1, 0, 0, 0};
        tbl[4] = '{0, 1, 0, 1, 1, 0};
        tbl[5] = '{1, 1, 1, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0};

        rstn = 1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        model_reset();
        cyc = 0;
        #2 rstn = 0;
        @(negedge clk);

        // reset held with both requests high
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 19'h00123, 1, 19'h00456, 12'hABC);
            chk("rst_outputs", {rd_gnt, wr_gnt, rd_valid, mem_en, mem_we, starve}, 0);
            advance();
        end
        apply(1, 1, 19'h00123, 1, 19'h00456, 12'hABC);
        chk("release_no_gnt", {rd_gnt, wr_gnt}, 0);
        advance();
        apply(1, 1, 19'h00123, 1, 19'h00456, 12'hABC);
        chk("both_req_rd_wins", {rd_gnt, wr_gnt}, 2'b10);
        advance();
        apply(1, 0, 19'h00123, 1, 19'h00456, 12'hABC);
        chk("wr_after_rd", {rd_gnt, wr_gnt}, 2'b01);
        advance();
        idle(4);

        // table-driven grant / strobe sequence
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, tbl[i].rr, 19'(i * 3), tbl[i].wr, 19'(i * 5 + 1), 12'(i + 12'h200));
            chk("tbl_rd_gnt", rd_gnt, tbl[i].erg);
            chk("tbl_wr_gnt", wr_gnt, tbl[i].ewg);
            chk("tbl_mem_en", mem_en, tbl[i].een);
            chk("tbl_mem_we", mem_we, tbl[i].ewe);
            advance();
        end

        // single read latency
        do_reset();
        apply(1, 1, 19'h00100, 0, '0, '0);
        chk("single_rd_gnt", rd_gnt, 1);
        advance();
        apply(1, 0, '0, 0, '0, '0);
        chk("single_mem_en", {mem_en, mem_we}, 2'b10);
        chk("single_mem_addr", mem_addr, 19'h00100);
        advance();
        apply(1, 0, '0, 0, '0, '0);
        chk("single_not_yet", rd_valid, 0);
        advance();
        apply(1, 0, '0, 0, '0, '0);
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 12'h100);
        advance();
        idle(2);

        // continuous reads and writes: forced write slot every WMAX+1 cycles
        do_reset();
        ra = '0; wa = 19'h40000; wd = 12'h001;
        last = -1; nwg = 0; nst = 0; nrg = 0;
        for (int i = 0; i < 640; i++) begin
            apply(1, 1, ra, 1, wa, wd);
            if (starve) nst++;
            if (rd_gnt) nrg++;
            if (wr_gnt) begin
                if (last < 0) chk("first_forced_wr", i, WMAX);
                else          chk("forced_wr_gap", i - last, WMAX + 1);
                last = i;
                nwg++;
            end
            if (e_rg) ra = ra + 1'b1;
            if (e_wg) begin wa = wa + 1'b1; wd = wd + 1'b1; end
            advance();
        end
        chk("forced_wr_count", nwg, 37);
        chk("starve_pulses",   nst, 37);
        chk("rd_gnt_count",    nrg, 603);
        idle(5);

        // streaming reads
        do_reset();
        nv = 0; nv4 = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 108; i++) begin
            apply(1, i < 100, 19'(i + 19'h00200), 0, '0, '0);
            if (rd_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
            if (rd_valid4) nv4++;
            advance();
        end
        chk("stream_pulses",   nv, 100);
        chk("stream_no_gaps",  last_v - first_v, 99);
        chk("stream_pulses_l4", nv4, 100);

        // reset with reads in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 19'(i + 19'h00010), 0, '0, '0);
            advance();
        end
        idle(1);
        apply(0, 0, '0, 0, '0, '0);
        nv = rd_valid; nv4 = rd_valid4;
        advance();
        for (int i = 0; i < 12; i++) begin
            apply(1, 0, '0, 0, '0, '0);
            nv += rd_valid; nv4 += rd_valid4;
            advance();
        end
        chk("flush_valid_l2", nv, 0);
        chk("flush_valid_l4", nv4, 0);

        // randomized traffic against the model
        do_reset();
        pend = 0; ra = '0; wa = '0; wd = '0;
        begin
            bit rr, rn;
            rr = 0;
            for (int i = 0; i < 1500; i++) begin
                rn = ($urandom_range(0, 399) != 0);
                if (!rr || e_rg) begin
                    rr = ($urandom_range(0, 3) != 0);
                    ra = 19'($urandom);
                end
                if (!pend) begin
                    pend = ($urandom_range(0, 2) == 0);
                    wa = 19'($urandom);
                    wd = 12'($urandom);
                end else if ($urandom_range(0, 49) == 0) begin
                    pend = 0;
                end
                apply(rn, rr, ra, pend, wa, wd);
                if (e_wg || !rn) pend = 0;
                if (!rn) rr = 0;
                advance();
            end
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
